// File: rtl/memmu_cartesian_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : memmu_cartesian_write_buffer
// Purpose  : Buffers registered address/payload pairs from the cartesian
//            representation stage in a FIFO and writes them to external
//            memory through a single-outstanding req/ack write port. Counts
//            writes per frame and pulses frameDone once a frame-end request
//            has been fully drained.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   i_SYSTEM_clk / i_SYSTEM_rst      clock, synchronous active-low reset
//   i_MemMU_CR_valid/address/payload incoming pair (19-bit word addr, 64-bit)
//   i_MemMU_CR_size                  current frame size, sampled at frame end
//   i_MemMU_frameEnd                 one-cycle frame-close request
//   o_MemMU_WB_ready                 FIFO not full
//   o_MEM_wrReq/wrAddr/wrData        registered memory write request
//   i_MEM_wrAck                      write accepted (valid while wrReq high)
//   o_MemMU_WB_frameDone             one-cycle pulse, frame fully written
//   o_MemMU_WB_frameCount            writes in the last closed frame
//   o_MemMU_WB_frameSize             size sampled at the last frame end
//   o_MemMU_WB_overflow              sticky, a pair was dropped on full
// ============================================================================
module memmu_cartesian_write_buffer #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        i_SYSTEM_clk,
   input  logic        i_SYSTEM_rst,
   input  logic        i_MemMU_CR_valid,
   input  logic [18:0] i_MemMU_CR_address,
   input  logic [63:0] i_MemMU_CR_payload,
   input  logic [18:0] i_MemMU_CR_size,
   input  logic        i_MemMU_frameEnd,
   output logic        o_MemMU_WB_ready,
   output logic        o_MEM_wrReq,
   output logic [31:0] o_MEM_wrAddr,
   output logic [63:0] o_MEM_wrData,
   input  logic        i_MEM_wrAck,
   output logic        o_MemMU_WB_frameDone,
   output logic [18:0] o_MemMU_WB_frameCount,
   output logic [18:0] o_MemMU_WB_frameSize,
   output logic        o_MemMU_WB_overflow
);

   localparam int unsigned   c_AW       = $clog2(FIFO_DEPTH);
   localparam logic [c_AW:0] c_FULL_CNT = (c_AW + 1)'(FIFO_DEPTH);
   localparam logic [18:0]   c_CNT_MAX  = 19'h7FFFF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [18:0]     r_fifo_addr [FIFO_DEPTH];
   logic [63:0]     r_fifo_data [FIFO_DEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW:0]   r_count;

   logic        r_wr_req;
   logic [31:0] r_wr_addr;
   logic [63:0] r_wr_data;
   logic [18:0] r_wr_cnt;
   logic [18:0] r_frame_count;
   logic [18:0] r_frame_size;
   logic        r_pending;
   logic        r_overflow;

   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic        w_req_clr;
   logic        w_cnt_inc;
   logic        w_close;
   logic [31:0] w_head_byte_addr;

   // Full is judged on the occupancy before this edge, so a push into a full
   // FIFO is dropped even if the FSM pops on the same edge.
   assign w_full  = (r_count == c_FULL_CNT);
   assign w_empty = (r_count == '0);
   assign w_push  = i_MemMU_CR_valid && !w_full;

   // Word address -> byte address; the 32-bit sum wraps naturally.
   assign w_head_byte_addr = BASE_ADDR + {13'b0, r_fifo_addr[r_rd_ptr], 3'b000};

   // ------------------------------------------------------------------ FIFO
   always_ff @(posedge i_SYSTEM_clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= i_MemMU_CR_address;
         r_fifo_data[r_wr_ptr] <= i_MemMU_CR_payload;
      end
   end

   always_ff @(posedge i_SYSTEM_clk) begin
      if (!i_SYSTEM_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge i_SYSTEM_clk) begin
      if (!i_SYSTEM_rst) r_state <= S_IDLE;
      else               r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_req_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      w_close     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_WRITE;
            end else if (r_pending) begin
               w_state_nxt = S_DONE;
            end
         end
         S_WRITE: begin
            if (i_MEM_wrAck) begin
               w_cnt_inc = 1'b1;
               // Load the next entry on the ack edge so req stays high and
               // a continuously acked port sees one write per cycle.
               if (!w_empty) begin
                  w_pop = 1'b1;
               end else begin
                  w_req_clr   = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_DONE: begin
            w_close     = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // -------------------------------------------------------- write datapath
   always_ff @(posedge i_SYSTEM_clk) begin
      if (!i_SYSTEM_rst) begin
         r_wr_req  <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else if (w_pop) begin
         r_wr_req  <= 1'b1;
         r_wr_addr <= w_head_byte_addr;
         r_wr_data <= r_fifo_data[r_rd_ptr];
      end else if (w_req_clr) begin
         r_wr_req  <= 1'b0;
      end
   end

   // ----------------------------------------------------- frame bookkeeping
   always_ff @(posedge i_SYSTEM_clk) begin
      if (!i_SYSTEM_rst) begin
         r_wr_cnt      <= '0;
         r_frame_count <= '0;
         r_frame_size  <= '0;
         r_pending     <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         if (w_close) begin
            r_frame_count <= r_wr_cnt;
            r_wr_cnt      <= '0;
         end else if (w_cnt_inc && (r_wr_cnt != c_CNT_MAX)) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
         end

         // A frame end seen while closing the previous frame opens the
         // request for the next one, so it takes priority over the clear.
         if (i_MemMU_frameEnd) begin
            r_pending    <= 1'b1;
            r_frame_size <= i_MemMU_CR_size;
         end else if (w_close) begin
            r_pending    <= 1'b0;
         end

         if (i_MemMU_CR_valid && w_full) r_overflow <= 1'b1;
      end
   end

   assign o_MemMU_WB_ready      = !w_full;
   assign o_MEM_wrReq           = r_wr_req;
   assign o_MEM_wrAddr          = r_wr_addr;
   assign o_MEM_wrData          = r_wr_data;
   assign o_MemMU_WB_frameDone  = (r_state == S_DONE);
   assign o_MemMU_WB_frameCount = r_frame_count;
   assign o_MemMU_WB_frameSize  = r_frame_size;
   assign o_MemMU_WB_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_memmu_cartesian_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_memmu_cartesian_write_buffer
// Purpose  : Self-checking bench. Two instances share all inputs and differ
//            only in BASE_ADDR (0x1000 and 0xFFFF_FFF8, the latter exercising
//            address wrap). A queue-based reference model tracks the
//            buffer contents, write port and frame bookkeeping; directed
//            scenarios are followed by a long randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memmu_cartesian_write_buffer;

   localparam int          DEPTH     = 16;
   localparam logic [31:0] BASE_MAIN = 32'h0000_1000;
   localparam logic [31:0] BASE_WRAP = 32'hFFFF_FFF8;

   logic        clk;
   logic        rst_n;
   logic        cr_valid;
   logic [18:0] cr_address;
   logic [63:0] cr_payload;
   logic [18:0] cr_size;
   logic        frame_end;
   logic        wr_ack;

   logic        wb_ready,    wrap_ready;
   logic        wr_req,      wrap_req;
   logic [31:0] wr_addr,     wrap_addr;
   logic [63:0] wr_data,     wrap_data;
   logic        frame_done,  wrap_done;
   logic [18:0] frame_count, wrap_count;
   logic [18:0] frame_size,  wrap_size;
   logic        overflow,    wrap_ovf;

   memmu_cartesian_write_buffer #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE_MAIN)) u_dut (
      .i_SYSTEM_clk         (clk),
      .i_SYSTEM_rst         (rst_n),
      .i_MemMU_CR_valid     (cr_valid),
      .i_MemMU_CR_address   (cr_address),
      .i_MemMU_CR_payload   (cr_payload),
      .i_MemMU_CR_size      (cr_size),
      .i_MemMU_frameEnd     (frame_end),
      .o_MemMU_WB_ready     (wb_ready),
      .o_MEM_wrReq          (wr_req),
      .o_MEM_wrAddr         (wr_addr),
      .o_MEM_wrData         (wr_data),
      .i_MEM_wrAck          (wr_ack),
      .o_MemMU_WB_frameDone (frame_done),
      .o_MemMU_WB_frameCount(frame_count),
      .o_MemMU_WB_frameSize (frame_size),
      .o_MemMU_WB_overflow  (overflow)
   );

   memmu_cartesian_write_buffer #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE_WRAP)) u_wrap (
      .i_SYSTEM_clk         (clk),
      .i_SYSTEM_rst         (rst_n),
      .i_MemMU_CR_valid     (cr_valid),
      .i_MemMU_CR_address   (cr_address),
      .i_MemMU_CR_payload   (cr_payload),
      .i_MemMU_CR_size      (cr_size),
      .i_MemMU_frameEnd     (frame_end),
      .o_MemMU_WB_ready     (wrap_ready),
      .o_MEM_wrReq          (wrap_req),
      .o_MEM_wrAddr         (wrap_addr),
      .o_MEM_wrData         (wrap_data),
      .i_MEM_wrAck          (wr_ack),
      .o_MemMU_WB_frameDone (wrap_done),
      .o_MemMU_WB_frameCount(wrap_count),
      .o_MemMU_WB_frameSize (wrap_size),
      .o_MemMU_WB_overflow  (wrap_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_compared   = 0;
   int n_mismatched = 0;
   int n_writes     = 0;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ------------------------------------------------------ reference model
   logic [82:0] m_q[$];          // {word address, payload} awaiting write
   bit          m_req;
   logic [31:0] m_addr, m_waddr;
   logic [63:0] m_data;
   bit          m_done, m_pending, m_ovf;
   logic [18:0] m_cnt, m_fcount, m_fsize;

   function automatic logic [31:0] byte_addr(input logic [31:0] base, input logic [18:0] a);
      return base + {13'b0, a, 3'b000};
   endfunction

   task automatic take_head();
      logic [82:0] e;
      e       = m_q.pop_front();
      m_addr  = byte_addr(BASE_MAIN, e[82:64]);
      m_waddr = byte_addr(BASE_WRAP, e[82:64]);
      m_data  = e[63:0];
   endtask

   // Applies one clock edge worth of behaviour using the inputs present at it.
   task automatic model_edge();
      bit full, nonempty;
      if (!rst_n) begin
         m_q.delete();
         m_req = 0; m_addr = '0; m_waddr = '0; m_data = '0;
         m_done = 0; m_pending = 0; m_ovf = 0;
         m_cnt = '0; m_fcount = '0; m_fsize = '0;
         return;
      end
      full     = (m_q.size() == DEPTH);
      nonempty = (m_q.size() != 0);
      if (m_done) begin
         m_fcount  = m_cnt;
         m_cnt     = '0;
         m_pending = 0;
         m_done    = 0;
      end else if (m_req) begin
         if (wr_ack) begin
            if (m_cnt != 19'h7FFFF) m_cnt = m_cnt + 19'd1;
            if (nonempty) take_head();
            else          m_req = 0;
         end
      end else if (nonempty) begin
         take_head();
         m_req = 1;
      end else if (m_pending) begin
         m_done = 1;
      end
      if (cr_valid) begin
         if (full) m_ovf = 1;
         else      m_q.push_back({cr_address, cr_payload});
      end
      if (frame_end) begin
         m_pending = 1;
         m_fsize   = cr_size;
      end
   endtask

   task automatic compare_all();
      bit m_ready;
      m_ready = (m_q.size() < DEPTH);
      check_value("ready",      wb_ready,    m_ready);
      check_value("req",        wr_req,      m_req);
      check_value("addr",       wr_addr,     m_addr);
      check_value("data",       wr_data,     m_data);
      check_value("done",       frame_done,  m_done);
      check_value("fcount",     frame_count, m_fcount);
      check_value("fsize",      frame_size,  m_fsize);
      check_value("ovf",        overflow,    m_ovf);
      check_value("wrap_ready", wrap_ready,  m_ready);
      check_value("wrap_req",   wrap_req,    m_req);
      check_value("wrap_addr",  wrap_addr,   m_waddr);
      check_value("wrap_data",  wrap_data,   m_data);
      check_value("wrap_done",  wrap_done,   m_done);
      check_value("wrap_count", wrap_count,  m_fcount);
      check_value("wrap_size",  wrap_size,   m_fsize);
      check_value("wrap_ovf",   wrap_ovf,    m_ovf);
   endtask

   // Inputs are set at the falling edge; one step = rising edge + model
   // update + comparison at the next falling edge.
   task automatic step();
      if (rst_n === 1'b1 && wr_req === 1'b1 && wr_ack === 1'b1) n_writes++;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic push(input logic [18:0] a, input logic [63:0] d);
      cr_valid = 1'b1; cr_address = a; cr_payload = d;
      step();
      cr_valid = 1'b0;
   endtask

   task automatic wait_req_low(input string tag, input int max);
      int k = 0;
      while (wr_req !== 1'b0 && k < max) begin step(); k++; end
      check_value(tag, wr_req, 1'b0);
   endtask

   task automatic wait_done(input string tag, input int max);
      int k = 0;
      while (frame_done !== 1'b1 && k < max) begin step(); k++; end
      check_value(tag, frame_done, 1'b1);
   endtask

   task automatic close_frame(input logic [18:0] sz, input logic [18:0] exp_count, input string tag);
      frame_end = 1'b1; cr_size = sz;
      step();
      frame_end = 1'b0;
      wait_done({tag, "_done"}, 40);
      step();
      check_value({tag, "_count"}, frame_count, exp_count);
      check_value({tag, "_size"},  frame_size,  sz);
   endtask

   initial begin
      int ack_pct;
      bit hold;
      rst_n = 1'b0; cr_valid = 1'b0; cr_address = '0; cr_payload = '0;
      cr_size = '0; frame_end = 1'b0; wr_ack = 1'b0;
      @(negedge clk);
      repeat (2) step();
      rst_n = 1'b1;
      check_value("rst_req",   wr_req,   1'b0);
      check_value("rst_addr",  wr_addr,  32'h0);
      check_value("rst_ready", wb_ready, 1'b1);

      // Single point: two-cycle latency, stable while waiting, falls on ack.
      push(19'd5, 64'hDEAD_BEEF_0123_4567);
      check_value("lat1_req", wr_req, 1'b0);
      step();
      check_value("lat2_req",     wr_req,    1'b1);
      check_value("single_addr",  wr_addr,   32'h0000_1028);
      check_value("single_waddr", wrap_addr, 32'h0000_0020);
      check_value("single_data",  wr_data,   64'hDEAD_BEEF_0123_4567);
      repeat (3) begin
         step();
         check_value("hold_req",  wr_req,  1'b1);
         check_value("hold_addr", wr_addr, 32'h0000_1028);
      end
      wr_ack = 1'b1;
      step();
      wr_ack = 1'b0;
      check_value("single_fall", wr_req, 1'b0);

      // Idle, empty: frameDone exactly one cycle after the frameEnd edge.
      frame_end = 1'b1; cr_size = 19'd1234;
      step();
      frame_end = 1'b0;
      check_value("fe_done_f", frame_done, 1'b0);
      step();
      check_value("fe_done_f1", frame_done, 1'b1);
      step();
      check_value("fe_done_f2", frame_done,  1'b0);
      check_value("fe_count1",  frame_count, 19'd1);
      close_frame(19'd77, 19'd0, "empty_frame");

      // Burst of 20 with ack held high.
      wr_ack = 1'b1; n_writes = 0;
      for (int i = 0; i < 20; i++) push(19'($urandom), {$urandom, $urandom});
      wait_req_low("burst_drain", 10);
      check_value("burst_writes", n_writes, 20);
      check_value("burst_ovf",    overflow, 1'b0);
      wr_ack = 1'b0;
      close_frame(19'($urandom), 19'd20, "burst_frame");

      // Ack held low: one entry sits in the write register, the FIFO fills
      // after the 17th push and the 18th is dropped.
      for (int i = 0; i < 18; i++) begin
         push(19'($urandom), {$urandom, $urandom});
         if (i == 15) check_value("fill16_ready", wb_ready, 1'b1);
         if (i == 16) check_value("fill17_ready", wb_ready, 1'b0);
      end
      check_value("fill_ovf", overflow, 1'b1);
      wr_ack = 1'b1; n_writes = 0;
      wait_req_low("fill_drain", 40);
      check_value("fill_writes",  n_writes, 17);
      check_value("fill_ovf_sty", overflow, 1'b1);
      wr_ack = 1'b0;
      close_frame(19'd17, 19'd17, "fill_frame");

      // Address wrap on the high-base instance.
      push(19'h7FFFF, 64'h0123_4567_89AB_CDEF);
      step();
      check_value("wrap_hi_addr",  wrap_addr, 32'h003F_FFF0);
      check_value("wrap_main_addr", wr_addr,  32'h0040_0FF8);
      // Reset while the write is still outstanding; a late ack is ignored.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_value("mid_rst_req",  wr_req,   1'b0);
      check_value("mid_rst_data", wr_data,  64'h0);
      check_value("mid_rst_ovf",  overflow, 1'b0);
      wr_ack = 1'b1;
      step();
      wr_ack = 1'b0;
      check_value("late_ack_req", wr_req, 1'b0);
      close_frame(19'd3, 19'd0, "post_rst_frame");

      // Randomized run; upstream holds valid low from frameEnd to frameDone.
      hold = 0; ack_pct = 50;
      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) begin
            case ($urandom_range(0, 3))
               0: ack_pct = 5;
               1: ack_pct = 40;
               2: ack_pct = 80;
               default: ack_pct = 100;
            endcase
         end
         rst_n      = ($urandom_range(0, 999) != 0);
         if (!rst_n) hold = 0;
         frame_end  = ($urandom_range(0, 99) < 2);
         if (frame_end) hold = 1;
         cr_valid   = !hold && ($urandom_range(0, 99) < 60);
         cr_address = 19'($urandom);
         cr_payload = {$urandom, $urandom};
         cr_size    = 19'($urandom);
         wr_ack     = ($urandom_range(0, 99) < ack_pct);
         step();
         if (frame_done === 1'b1) hold = 0;
      end
      rst_n = 1'b1; cr_valid = 1'b0; frame_end = 1'b0; wr_ack = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
`default_nettype wire
